// File: rtl/alu_result_stage.sv
// Execute-stage result register: captures ALU results with their destination
// tag, maintains the N/Z/V/C flag register and hands entries to writeback
// through a valid/ready handshake backed by a two-entry skid buffer.
module alu_result_stage #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,

  // ALU side
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_cout,
  input  logic               alu_cin_msb,
  input  logic [2:0]         alu_op,
  input  logic [REGBITS-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               set_flags,

  // Writeback side
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [REGBITS-1:0] out_rd,
  output logic               out_reg_write,

  // Architectural flag register
  output logic               flag_n,
  output logic               flag_z,
  output logic               flag_v,
  output logic               flag_c
);

  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0]   result;
    logic [REGBITS-1:0] rd;
    logic               reg_write;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q;

  logic   flag_n_q, flag_z_q, flag_v_q, flag_c_q;
  logic   flag_n_d, flag_z_d, flag_v_d, flag_c_d;
  logic   new_n, new_z, new_v, new_c;
  logic   is_arith;

  logic   accept;
  logic   drain;

  // Handshake qualifiers; reset is handled by register priority below.
  always_comb begin
    accept   = in_valid && in_ready_q && !flush;
    drain    = (state_q != StEmpty) && out_ready;
    in_entry = '{result: alu_result, rd: in_rd, reg_write: in_reg_write};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush forces empty regardless of handshakes.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) state_d = StOne;
        end
        StOne: begin
          if (accept && !drain) begin
            state_d = StFull;
          end else if (!accept && drain) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (drain) state_d = StOne;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Output logic; in_ready comes from a register so out_ready never reaches the ALU.
  always_comb begin
    out_valid     = (state_q != StEmpty);
    in_ready      = in_ready_q;
    out_result    = head_q.result;
    out_rd        = head_q.rd;
    out_reg_write = head_q.reg_write;
    flag_n        = flag_n_q;
    flag_z        = flag_z_q;
    flag_v        = flag_v_q;
    flag_c        = flag_c_q;
  end

  // Entry steering: the head always holds the oldest entry, the skid the younger one.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (!flush) begin
      unique case (state_q)
        StEmpty: begin
          if (accept) head_d = in_entry;
        end
        StOne: begin
          if (accept && drain) begin
            head_d = in_entry;
          end else if (accept) begin
            skid_d = in_entry;
          end
        end
        StFull: begin
          if (drain) head_d = skid_q;
        end
        default: ;
      endcase
    end
  end

  // Entry storage and registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  // Condition codes from the incoming result; only add/sub carry meaningful C/V.
  always_comb begin
    is_arith = (alu_op == OpAdd) || (alu_op == OpSub);
    new_n    = alu_result[WIDTH-1];
    new_z    = (alu_result == '0);
    new_c    = is_arith ? alu_cout : 1'b0;
    new_v    = is_arith ? (alu_cout ^ alu_cin_msb) : 1'b0;
  end

  // Flag register next state: written at accept time, never at drain.
  always_comb begin
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    flag_c_d = flag_c_q;
    if (accept && set_flags) begin
      flag_n_d = new_n;
      flag_z_d = new_z;
      flag_v_d = new_v;
      flag_c_d = new_c;
    end
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
      flag_c_q <= flag_c_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned REGBITS = 5;

  logic               clk;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_cout;
  logic               alu_cin_msb;
  logic [2:0]         alu_op;
  logic [REGBITS-1:0] in_rd;
  logic               in_reg_write;
  logic               set_flags;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic [REGBITS-1:0] out_rd;
  logic               out_reg_write;
  logic               flag_n, flag_z, flag_v, flag_c;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(
    .WIDTH  (WIDTH),
    .REGBITS(REGBITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_cin_msb  (alu_cin_msb),
    .alu_op       (alu_op),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .set_flags    (set_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .flag_c       (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REGBITS-1:0] rd, input logic [WIDTH-1:0] res,
                       input logic [2:0] op, input logic co, input logic cm, input logic sf);
    in_valid     = v;
    in_rd        = rd;
    alu_result   = res;
    alu_op       = op;
    alu_cout     = co;
    alu_cin_msb  = cm;
    set_flags    = sf;
    in_reg_write = v;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_result !== '0 || out_rd !== '0 || out_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: result=%h rd=%0d we=%0b want 0", out_result, out_rd, out_reg_write);
    end
    checks++;
    if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: nzvc=%b want 0000", {flag_n, flag_z, flag_v, flag_c});
    end
  endtask

  task automatic test_add_stream();
    out_ready = 1'b1;
    drive(1'b1, 5'd7, 64'h7FFF_FFFF_FFFF_FFFF + 64'd1, 3'b010, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'h8000_0000_0000_0000 || out_rd !== 5'd7
        || out_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL add_out: valid=%0b result=%h rd=%0d we=%0b want 1/8000000000000000/7/1",
               out_valid, out_result, out_rd, out_reg_write);
    end
    checks++;
    if ({flag_n, flag_z, flag_v, flag_c} !== 4'b1010) begin
      errors++;
      $display("FAIL add_flags: nzvc=%b want 1010", {flag_n, flag_z, flag_v, flag_c});
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_sub_and();
    out_ready = 1'b1;
    drive(1'b1, 5'd3, 64'd0, 3'b011, 1'b1, 1'b1, 1'b1);
    step();
    checks++;
    if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101 || out_result !== '0 || out_rd !== 5'd3) begin
      errors++;
      $display("FAIL sub_flags: nzvc=%b rd=%0d want 0101 rd 3", {flag_n, flag_z, flag_v, flag_c},
               out_rd);
    end
    // and with set_flags=0 while the sub drains: head replaced, flags untouched
    drive(1'b1, 5'd4, 64'd0, 3'b100, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    checks++;
    if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
      errors++;
      $display("FAIL and_noflags: nzvc=%b want 0101", {flag_n, flag_z, flag_v, flag_c});
    end
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd4) begin
      errors++;
      $display("FAIL and_head: valid=%0b rd=%0d want 1/4", out_valid, out_rd);
    end
    step();
  endtask

  task automatic test_logic_flags();
    out_ready = 1'b1;
    // add setting C=1, V=1 so the logic op has something to clear
    drive(1'b1, 5'd5, 64'd1, 3'b010, 1'b1, 1'b0, 1'b1);
    step();
    checks++;
    if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0011) begin
      errors++;
      $display("FAIL addcv_flags: nzvc=%b want 0011", {flag_n, flag_z, flag_v, flag_c});
    end
    drive(1'b1, 5'd6, 64'hF0, 3'b110, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    checks++;
    if ({flag_n, flag_z, flag_v, flag_c} !== 4'b0000 || out_result !== 64'hF0) begin
      errors++;
      $display("FAIL xor_flags: nzvc=%b result=%h want 0000/f0", {flag_n, flag_z, flag_v, flag_c},
               out_result);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    logic acc;
    for (int cyc = 1; cyc <= 30 && got < 4; cyc++) begin
      out_ready = (cyc >= 2 && cyc <= 5) ? 1'b0 : 1'b1;
      if (sent < 4) drive(1'b1, REGBITS'(sent + 1), WIDTH'((sent + 1) * 'h1111), 3'b000, 1'b0,
                          1'b0, 1'b0);
      else idle();
      if (cyc == 2 || cyc == 7) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_hi c%0d: ready=%0b want 1", cyc, in_ready);
        end
      end
      if (cyc >= 3 && cyc <= 6) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd1
            || out_result !== 64'h1111) begin
          errors++;
          $display("FAIL bp_stall c%0d: ready=%0b valid=%0b rd=%0d result=%h want 0/1/1/1111",
                   cyc, in_ready, out_valid, out_rd, out_result);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_rd !== REGBITS'(got + 1) || out_result !== WIDTH'((got + 1) * 'h1111)) begin
          errors++;
          $display("FAIL bp_order: rd=%0d result=%h want %0d", out_rd, out_result, got + 1);
        end
        got++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    idle();
    checks++;
    if (got != 4 || sent != 4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_total: drained=%0d sent=%0d valid=%0b want 4/4/0", got, sent, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 64'd0, 3'b011, 1'b1, 1'b1, 1'b1);  // Z=1 C=1
    step();
    drive(1'b1, 5'd11, 64'd9, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_fill: ready=%0b want 0", in_ready);
    end
    flush = 1'b1;
    drive(1'b1, 5'd12, 64'h8000_0000_0000_0000, 3'b010, 1'b0, 1'b1, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1
        || {flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
      errors++;
      $display("FAIL flush_full: valid=%0b ready=%0b nzvc=%b want 0/1/0101", out_valid, in_ready,
               {flag_n, flag_z, flag_v, flag_c});
    end
    // flush in ONE with an acceptable input: nothing captured, no flag update
    flush = 1'b0;
    drive(1'b1, 5'd20, 64'd1, 3'b100, 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 5'd21, 64'h8000_0000_0000_0000, 3'b010, 1'b0, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    idle();
    step();
    checks++;
    if (out_valid !== 1'b0 || {flag_n, flag_z, flag_v, flag_c} !== 4'b0101) begin
      errors++;
      $display("FAIL flush_one: valid=%0b nzvc=%b want 0/0101", out_valid,
               {flag_n, flag_z, flag_v, flag_c});
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive(1'b1, 5'd13, 64'hFFFF, 3'b010, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd14, 64'hEEEE, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    test_reset();
    out_ready = 1'b1;
    drive(1'b1, 5'd15, 64'h1234, 3'b101, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd15 || out_result !== 64'h1234
        || {flag_n, flag_z, flag_v, flag_c} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_resume: valid=%0b rd=%0d result=%h nzvc=%b want 1/15/1234/0000",
               out_valid, out_rd, out_result, {flag_n, flag_z, flag_v, flag_c});
    end
    step();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_add_stream();
    test_sub_and();
    test_logic_flags();
    test_back_to_back();
    test_flush();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-stage result register for the in-order pipeline. It sits directly downstream of the WIDTH-bit ALU built from bit slices. It captures each ALU result with its destination tag and derives the N/Z/V/C condition codes, updating the architectural flag register. It then hands the result to writeback through a valid/ready handshake. A 2-entry skid buffer keeps full throughput under writeback back-pressure without a combinational ready path to the ALU.

## Interface
Parameters:
- WIDTH, 64, datapath width (number of ALU bit slices)
- REGBITS, 5, destination register index width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  ALU output valid this cycle
- in_ready  output  1  stage can accept; registered
- alu_result  input  WIDTH  ALU result bus (bitVal of all slices)
- alu_cout  input  1  carry out of slice WIDTH-1
- alu_cin_msb  input  1  carry into slice WIDTH-1
- alu_op  input  3  ALU select as driven to the slices (000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor)
- in_rd  input  REGBITS  destination register
- in_reg_write  input  1  result is written back
- set_flags  input  1  instruction updates flags
- out_valid  output  1  entry available to writeback
- out_ready  input  1  writeback accepts
- out_result  output  WIDTH  head-entry result
- out_rd  output  REGBITS  head-entry destination
- out_reg_write  output  1  head-entry write enable
- flag_n, flag_z, flag_v, flag_c  output  1 each  architectural flag register

## Operation
- Accept: in_valid && in_ready && !flush && !reset.
- Drain: out_valid && out_ready.
- Storage: head entry (drives outputs) and skid entry. The state machine has three states: EMPTY, ONE (head only) and FULL (head+skid).
  - EMPTY + accept → ONE.
  - ONE + accept + drain → ONE (new data into head).
  - ONE + accept + no drain → FULL (new data into skid).
  - ONE + drain + no accept → EMPTY.
  - FULL + drain → ONE (skid moves to head). FULL never accepts.
- in_ready is 0 in FULL and 1 otherwise. It is a registered function of the next state and has no combinational path from out_ready.
- Order is preserved strictly: the skid entry never bypasses the head.
- Flags are computed from the accepted inputs only, and the flag register is written on accept when set_flags=1:
  - N = alu_result[WIDTH-1].
  - Z = (alu_result == 0).
  - For alu_op 010/011: C = alu_cout and V = alu_cout ^ alu_cin_msb. Sub uses the no-borrow convention, so C=1 means A>=B unsigned.
  - For any other alu_op: C=0 and V=0.
- Accept with set_flags=0 leaves the flags unchanged. The flags update at accept, not at drain.
- Flush clears state to EMPTY, deasserts out_valid next cycle and leaves the flags unchanged. Flush overrides a simultaneous accept, so no flag update occurs and nothing is captured. A drain in the same cycle is still considered taken by writeback.
- reset has priority over flush and over all handshakes.

## Timing
- Reset values: out_valid=0, in_ready=1, out_result=0, out_rd=0, out_reg_write=0, flag_n=flag_z=flag_v=flag_c=0, state EMPTY.
- Reset mid-operation drops all entries in one cycle. in_ready is 1 in the cycle after reset deasserts.
- Latency: accept in cycle t gives out_valid=1 with that data in cycle t+1, when the stage was EMPTY or draining.
- Flags written by an accept in cycle t are visible on flag_* in cycle t+1.
- Throughput: 1 result/cycle while out_ready=1.
- A stall of k cycles absorbs at most one extra entry. in_ready falls the cycle after FULL is entered and rises the cycle after the first drain from FULL.
- The output bus holds stable while out_valid=1 && out_ready=0.

## Test plan
- Add stream: after reset, accept 0x7FFF_FFFF_FFFF_FFFF + 1 (alu_op=010, cout=0, cin_msb=1, set_flags=1) → next cycle out_result=0x8000_0000_0000_0000, N=1 Z=0 V=1 C=0.
- Sub equal: A=5, B=5 (alu_op=011, result 0, cout=1, cin_msb=1) → Z=1 C=1 V=0 N=0. Follow with an and (alu_op=100, result 0, set_flags=0) → flags unchanged.
- Back-pressure: stream rd=1,2,3,4 with out_ready=0 for cycles 2–5 → in_ready=0 from cycle 3. After out_ready=1, outputs appear in order rd=1,2,3,4 with no loss or duplication.
- Logic op flag clear: xor result 0xF0 with cout=1, set_flags=1 → C=0, V=0, Z=0, N=0.
- Flush in FULL with a simultaneous in_valid → out_valid=0 next cycle and in_ready=1. The flags equal their pre-flush values and the flushed input is never output.
- Reset while FULL and out_ready=0 → next cycle all outputs equal their reset values, then normal streaming resumes.
